// File: rtl/ex_mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// ex_mem_wb_pipe
//
// Back half of the 5-stage RISC-V pipeline: the EX/MEM and MEM/WB pipeline
// registers, the data-memory handshake controller and the two hazard stalls
// fed back to the front of the pipe. The EX/MEM and MEM/WB fields also feed
// the operand-bypass network.
//
// Optional feature (macro PIPE_STALL_CNT_EN): adds parameter CNT_W and
// output stall_cycles. This counter counts the cycles where mem_stall is 1
// and saturates at all-ones.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   ex_*                instruction currently in EX (gated by ex_valid)
//   id_rs1, id_rs2      ID-stage sources used by the load-use check
//   dmem_*              data-memory request/ready handshake
//   EX_MEM_*, MEM_WB_*  forwarding / writeback fields
//   wb_en               register-file write enable (once per instruction)
//   load_use_stall      hold PC and IF/ID, bubble into ID/EX
//   mem_stall           freeze PC, IF/ID and ID/EX while memory is busy
//   stall_cycles        (PIPE_STALL_CNT_EN only) saturating mem_stall count
// ---------------------------------------------------------------------------
module ex_mem_wb_pipe #(
    parameter int XLEN = 32
`ifdef PIPE_STALL_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_RegWrite,
    input  logic            ex_MemRead,
    input  logic            ex_MemWrite,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            EX_MEM_RegWrite,
    output logic [4:0]      EX_MEM_rd,
    output logic [XLEN-1:0] EX_MEM_result,
    output logic            MEM_WB_RegWrite,
    output logic [4:0]      MEM_WB_rd,
    output logic [XLEN-1:0] MEM_WB_result,
    output logic            wb_en,
    output logic            load_use_stall,
    output logic            mem_stall
`ifdef PIPE_STALL_CNT_EN
    , output logic [CNT_W-1:0] stall_cycles
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state_reg;

    // EX/MEM register
    logic            ex_mem_valid_reg;
    logic            ex_mem_regwrite_reg;
    logic            ex_mem_memread_reg;
    logic            ex_mem_memwrite_reg;
    logic [4:0]      ex_mem_rd_reg;
    logic [XLEN-1:0] ex_mem_result_reg;
    logic [XLEN-1:0] ex_mem_store_data_reg;

    // MEM/WB register
    logic            mem_wb_regwrite_reg;
    logic [4:0]      mem_wb_rd_reg;
    logic [XLEN-1:0] mem_wb_result_reg;
    // Set when MEM/WB was just loaded; cleared while it holds so a frozen
    // instruction is not written back a second time.
    logic            wb_fresh_reg;

    logic            mem_op;
    logic            stall;
    logic            wb_regwrite_next;
    logic [XLEN-1:0] wb_result_next;

    always_comb begin
        mem_op           = ex_mem_valid_reg & (ex_mem_memread_reg | ex_mem_memwrite_reg);
        // dmem_ready only matters while a request is outstanding.
        stall            = mem_op & ~dmem_ready;
        wb_result_next   = ex_mem_memread_reg ? dmem_rdata : ex_mem_result_reg;
        // Stores never write the register file, whatever the decoder said.
        wb_regwrite_next = ex_mem_regwrite_reg & ~ex_mem_memwrite_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg             <= ST_RUN;
            ex_mem_valid_reg      <= 1'b0;
            ex_mem_regwrite_reg   <= 1'b0;
            ex_mem_memread_reg    <= 1'b0;
            ex_mem_memwrite_reg   <= 1'b0;
            ex_mem_rd_reg         <= 5'd0;
            ex_mem_result_reg     <= '0;
            ex_mem_store_data_reg <= '0;
            mem_wb_regwrite_reg   <= 1'b0;
            mem_wb_rd_reg         <= 5'd0;
            mem_wb_result_reg     <= '0;
            wb_fresh_reg          <= 1'b0;
        end else begin
            // Memory-stage controller. While in WAIT the request and every
            // pipeline field hold because stall stays high.
            case (state_reg)
                ST_RUN:  if (stall) state_reg <= ST_WAIT;
                ST_WAIT: if (dmem_ready) state_reg <= ST_RUN;
                default: state_reg <= ST_RUN;
            endcase

            if (!stall) begin
                ex_mem_valid_reg      <= ex_valid;
                ex_mem_regwrite_reg   <= ex_valid & ex_RegWrite;
                ex_mem_memread_reg    <= ex_valid & ex_MemRead;
                ex_mem_memwrite_reg   <= ex_valid & ex_MemWrite;
                ex_mem_rd_reg         <= ex_rd;
                ex_mem_result_reg     <= ex_alu_result;
                ex_mem_store_data_reg <= ex_store_data;

                mem_wb_regwrite_reg   <= wb_regwrite_next;
                mem_wb_rd_reg         <= ex_mem_rd_reg;
                mem_wb_result_reg     <= wb_result_next;
                wb_fresh_reg          <= 1'b1;
            end else begin
                wb_fresh_reg          <= 1'b0;
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (stall && !(&stall_cnt_reg)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt_reg;
`endif

    // Address, direction and data come straight from EX/MEM so they are
    // stable for the whole handshake.
    assign dmem_req        = mem_op;
    assign dmem_we         = ex_mem_memwrite_reg;
    assign dmem_addr       = ex_mem_result_reg;
    assign dmem_wdata      = ex_mem_store_data_reg;

    assign EX_MEM_RegWrite = ex_mem_regwrite_reg;
    assign EX_MEM_rd       = ex_mem_rd_reg;
    assign EX_MEM_result   = ex_mem_result_reg;

    assign MEM_WB_RegWrite = mem_wb_regwrite_reg;
    assign MEM_WB_rd       = mem_wb_rd_reg;
    assign MEM_WB_result   = mem_wb_result_reg;
    assign wb_en           = mem_wb_regwrite_reg & wb_fresh_reg;

    assign mem_stall       = stall;
    assign load_use_stall  = ex_valid & ex_MemRead & (ex_rd != 5'd0) &
                             ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_wb_pipe
//
// Directed bench for ex_mem_wb_pipe. Every instruction that should write
// back pushes its {rd, data} into a queue when it is issued; a monitor pops
// and compares whenever wb_en is seen. Handshake, forwarding and stall
// outputs are checked inline by the stimulus process. Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ex_mem_wb_pipe;

    localparam int XLEN = 32;
`ifdef PIPE_STALL_CNT_EN
    localparam int CNT_W = 2;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite;
    logic [4:0]      ex_rd, id_rs1, id_rs2;
    logic [XLEN-1:0] ex_alu_result, ex_store_data;
    logic            dmem_req, dmem_we, dmem_ready;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic            EX_MEM_RegWrite, MEM_WB_RegWrite;
    logic [4:0]      EX_MEM_rd, MEM_WB_rd;
    logic [XLEN-1:0] EX_MEM_result, MEM_WB_result;
    logic            wb_en, load_use_stall, mem_stall;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_t;

    wb_t exp_q[$];

    always #5 clk = ~clk;

    ex_mem_wb_pipe #(
        .XLEN(XLEN)
`ifdef PIPE_STALL_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_RegWrite    (ex_RegWrite),
        .ex_MemRead     (ex_MemRead),
        .ex_MemWrite    (ex_MemWrite),
        .ex_rd          (ex_rd),
        .ex_alu_result  (ex_alu_result),
        .ex_store_data  (ex_store_data),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_rd      (EX_MEM_rd),
        .EX_MEM_result  (EX_MEM_result),
        .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .MEM_WB_rd      (MEM_WB_rd),
        .MEM_WB_result  (MEM_WB_result),
        .wb_en          (wb_en),
        .load_use_stall (load_use_stall),
        .mem_stall      (mem_stall)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cycles (stall_cycles)
`endif
    );

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s = 0x%0h (t=%0t)", name, act, $time);
        end
    endtask

    task automatic drv(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic [4:0] rd, input logic [XLEN-1:0] alu, input logic [XLEN-1:0] sd);
        ex_valid      = v;
        ex_RegWrite   = rw;
        ex_MemRead    = mr;
        ex_MemWrite   = mw;
        ex_rd         = rd;
        ex_alu_result = alu;
        ex_store_data = sd;
    endtask

    task automatic bubble();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
    endtask

    task automatic push(input logic [4:0] rd, input logic [XLEN-1:0] data);
        wb_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one write-back per wb_en pulse.
    always @(negedge clk) begin
        if (!rst && wb_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got rd=%0d data=0x%0h, expected no write-back (t=%0t)",
                         MEM_WB_rd, MEM_WB_result, $time);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_rd", {27'd0, MEM_WB_rd}, {27'd0, e.rd});
                chk("wb_data", MEM_WB_result, e.data);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        id_rs1     = 5'd0;
        id_rs2     = 5'd0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        bubble();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_exmem_rw", {31'd0, EX_MEM_RegWrite}, 32'd0);
        chk("rst_memwb_rw", {31'd0, MEM_WB_RegWrite}, 32'd0);
        chk("rst_exmem_res", EX_MEM_result, 32'd0);
        chk("rst_memwb_res", MEM_WB_result, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_lus", {31'd0, load_use_stall}, 32'd0);
`ifdef PIPE_STALL_CNT_EN
        chk("rst_stall_cnt", {30'd0, stall_cycles}, 32'd0);
`endif

        // ALU op: rd=5, 0x1234
        step(); drv(1, 1, 0, 0, 5'd5, 32'h1234, 0); push(5'd5, 32'h1234);
        step(); bubble();
        @(negedge clk);
        chk("alu_exmem_rw", {31'd0, EX_MEM_RegWrite}, 32'd1);
        chk("alu_exmem_rd", {27'd0, EX_MEM_rd}, 32'd5);
        chk("alu_exmem_res", EX_MEM_result, 32'h1234);
        chk("alu_wb_early", {31'd0, wb_en}, 32'd0);
        step();
        @(negedge clk);
        chk("alu_memwb_rw", {31'd0, MEM_WB_RegWrite}, 32'd1);
        chk("alu_memwb_rd", {27'd0, MEM_WB_rd}, 32'd5);
        step();
        @(negedge clk);
        chk("alu_wb_once", {31'd0, wb_en}, 32'd0);

        // Load-use detection (combinational, stays within one cycle)
        step();
        drv(1, 1, 1, 0, 5'd7, 32'h40, 0); id_rs1 = 5'd0; id_rs2 = 5'd7;
        #1 chk("lus_rs2", {31'd0, load_use_stall}, 32'd1);
        id_rs2 = 5'd0;
        #1 chk("lus_none", {31'd0, load_use_stall}, 32'd0);
        id_rs1 = 5'd7;
        #1 chk("lus_rs1", {31'd0, load_use_stall}, 32'd1);
        ex_rd = 5'd0; id_rs1 = 5'd0;
        #1 chk("lus_x0", {31'd0, load_use_stall}, 32'd0);
        ex_rd = 5'd7; id_rs1 = 5'd7; ex_MemRead = 1'b0;
        #1 chk("lus_notload", {31'd0, load_use_stall}, 32'd0);
        ex_MemRead = 1'b1; ex_valid = 1'b0;
        #1 chk("lus_invalid", {31'd0, load_use_stall}, 32'd0);
        bubble(); id_rs1 = 5'd0; id_rs2 = 5'd0;

        // 3-wait load behind an ALU op, with another ALU op frozen in EX
        step(); drv(1, 1, 0, 0, 5'd3, 32'h55, 0); push(5'd3, 32'h55);
        step(); drv(1, 1, 1, 0, 5'd8, 32'h100, 0); push(5'd8, 32'hDEADBEEF);
        step(); drv(1, 1, 0, 0, 5'd10, 32'h77, 0); push(5'd10, 32'h77);
        @(negedge clk);
        chk("wait0_req", {31'd0, dmem_req}, 32'd1);
        chk("wait0_we", {31'd0, dmem_we}, 32'd0);
        chk("wait0_addr", dmem_addr, 32'h100);
        chk("wait0_stall", {31'd0, mem_stall}, 32'd1);
        chk("wait0_exmem_rd", {27'd0, EX_MEM_rd}, 32'd8);
        for (int k = 1; k <= 2; k++) begin
            step();
            @(negedge clk);
            chk("waitn_req", {31'd0, dmem_req}, 32'd1);
            chk("waitn_addr", dmem_addr, 32'h100);
            chk("waitn_stall", {31'd0, mem_stall}, 32'd1);
            chk("waitn_wb_en", {31'd0, wb_en}, 32'd0);
            chk("waitn_memwb_rd", {27'd0, MEM_WB_rd}, 32'd3);
        end
        step(); dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("ready_req", {31'd0, dmem_req}, 32'd1);
        chk("ready_stall", {31'd0, mem_stall}, 32'd0);
        chk("ready_wb_en", {31'd0, wb_en}, 32'd0);
        step(); dmem_ready = 1'b0; dmem_rdata = '0; bubble();
        @(negedge clk);
        chk("post_exmem_rd", {27'd0, EX_MEM_rd}, 32'd10);
        chk("post_req", {31'd0, dmem_req}, 32'd0);
`ifdef PIPE_STALL_CNT_EN
        chk("stall_cnt_3", {30'd0, stall_cycles}, 32'd3);
`endif
        step();

        // Store, RegWrite=0
        step(); drv(1, 0, 0, 1, 5'd9, 32'h200, 32'hCAFEF00D);
        step(); bubble(); dmem_ready = 1'b1;
        @(negedge clk);
        chk("st_req", {31'd0, dmem_req}, 32'd1);
        chk("st_we", {31'd0, dmem_we}, 32'd1);
        chk("st_addr", dmem_addr, 32'h200);
        chk("st_wdata", dmem_wdata, 32'hCAFEF00D);
        chk("st_stall", {31'd0, mem_stall}, 32'd0);
        step(); dmem_ready = 1'b0;
        @(negedge clk);
        chk("st_memwb_rw", {31'd0, MEM_WB_RegWrite}, 32'd0);
        chk("st_wb_en", {31'd0, wb_en}, 32'd0);

        // Store with RegWrite=1 then a zero-wait load, back to back
        step(); drv(1, 1, 0, 1, 5'd11, 32'h204, 32'h1111);
        step(); drv(1, 1, 1, 0, 5'd12, 32'h300, 0); push(5'd12, 32'hA5A5A5A5); dmem_ready = 1'b1;
        @(negedge clk);
        chk("st2_exmem_rw", {31'd0, EX_MEM_RegWrite}, 32'd1);
        chk("st2_we", {31'd0, dmem_we}, 32'd1);
        chk("st2_stall", {31'd0, mem_stall}, 32'd0);
        step(); bubble(); dmem_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("st2_memwb_rw", {31'd0, MEM_WB_RegWrite}, 32'd0);
        chk("ld0_we", {31'd0, dmem_we}, 32'd0);
        chk("ld0_addr", dmem_addr, 32'h300);
        chk("ld0_stall", {31'd0, mem_stall}, 32'd0);
        step(); dmem_ready = 1'b0; dmem_rdata = '0;
        step();

        // Reset while waiting on memory
        step(); drv(1, 1, 1, 0, 5'd4, 32'h400, 0);
        step(); bubble();
        @(negedge clk);
        chk("rw_stall1", {31'd0, mem_stall}, 32'd1);
        step();
        @(negedge clk);
        chk("rw_stall2", {31'd0, dmem_req}, 32'd1);
`ifdef PIPE_STALL_CNT_EN
        chk("stall_cnt_sat", {30'd0, stall_cycles}, 32'd3);
`endif
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("rw_req", {31'd0, dmem_req}, 32'd0);
        chk("rw_stall", {31'd0, mem_stall}, 32'd0);
        chk("rw_exmem_rw", {31'd0, EX_MEM_RegWrite}, 32'd0);
        chk("rw_memwb_rw", {31'd0, MEM_WB_RegWrite}, 32'd0);
        chk("rw_wb_en", {31'd0, wb_en}, 32'd0);
`ifdef PIPE_STALL_CNT_EN
        chk("rw_stall_cnt", {30'd0, stall_cycles}, 32'd0);
`endif
        step();

        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_wb_pipe.md
Name: ex_mem_wb_pipe

Overview:
- Producer side of the operand-forwarding interface: EX/MEM and MEM/WB pipeline registers plus the memory-stage controller of the 5-stage RISC-V core.
- Drives EX_MEM_RegWrite/rd, MEM_WB_RegWrite/rd and matching result buses for operand bypass.
- Performs the data-memory req/ready handshake with variable latency.
- Generates the load-use stall and the memory-wait stall for the front of the pipeline.

Parameters:
XLEN, 32, datapath width
CNT_W, 32, width of stall-cycle counter (optional feature only)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX stage holds a real instruction (0 = bubble/flushed)
ex_RegWrite  in  1  EX instruction writes rd
ex_MemRead  in  1  EX instruction is a load
ex_MemWrite  in  1  EX instruction is a store
ex_rd  in  5  EX destination register
ex_alu_result  in  XLEN  ALU result / memory address
ex_store_data  in  XLEN  store data (already forwarded)
id_rs1  in  5  ID-stage source 1 (load-use check)
id_rs2  in  5  ID-stage source 2
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  XLEN  request address
dmem_wdata  out  XLEN  store data
dmem_ready  in  1  memory completes request this cycle (rdata valid if load)
dmem_rdata  in  XLEN  load data
EX_MEM_RegWrite  out  1  forwarding: EX/MEM writes rd
EX_MEM_rd  out  5  forwarding: EX/MEM destination
EX_MEM_result  out  XLEN  forwarding: EX/MEM ALU result
MEM_WB_RegWrite  out  1  forwarding: MEM/WB writes rd
MEM_WB_rd  out  5  forwarding: MEM/WB destination
MEM_WB_result  out  XLEN  forwarding/writeback data
wb_en  out  1  register-file write enable
load_use_stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
mem_stall  out  1  freeze PC, IF/ID and ID/EX

Behaviour:
- Reset: all EX/MEM and MEM/WB fields cleared (valid, RegWrite, MemRead, MemWrite 0; rd 0; data 0). FSM goes to RUN. wb_en=0, dmem_req=0, both stall outputs 0 on the first cycle after reset.
- EX/MEM fields are gated by ex_valid: RegWrite = ex_valid & ex_RegWrite, and likewise for MemRead and MemWrite.
- mem_op = EX_MEM_valid & (MemRead | MemWrite).
- mem_stall = mem_op & ~dmem_ready (combinational).
- dmem_req = mem_op. Address, we and wdata come straight from EX/MEM registers, so they stay stable while waiting.
- FSM RUN: if mem_op & ~dmem_ready, go to WAIT.
- FSM WAIT: dmem_req stays high and all registers hold. Go to RUN on the cycle dmem_ready=1; that cycle, the data is captured into MEM/WB.
- dmem_ready is ignored while dmem_req=0.
- When mem_stall=0, every cycle:
  - EX/MEM loads the ex_* inputs.
  - MEM/WB loads EX/MEM: result = MemRead ? dmem_rdata : EX_MEM_result; RegWrite, rd copied; stores get RegWrite=0.
- When mem_stall=1: EX/MEM and MEM/WB hold, so the forwarding outputs stay valid for the frozen EX instruction.
- wb_en = MEM_WB_RegWrite & wb_fresh. wb_fresh is set on each MEM/WB load and cleared while holding, so each instruction writes back exactly once.
- Latency: zero-wait load gives data on MEM_WB_result 2 cycles after EX. ALU results appear on EX_MEM_result 1 cycle after EX.
- load_use_stall = ex_valid & ex_MemRead & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2). Combinational. The EX load still advances normally.
- EX_MEM_RegWrite is asserted for loads. The load-use stall guarantees EX/MEM never forwards a load address as data.
- rd=x0: RegWrite propagates unchanged; the forwarding consumer and register file ignore x0.
- Simultaneous mem_stall and load_use_stall: mem_stall dominates and EX inputs are not captured. load_use_stall re-evaluates after release.
- Reset mid-WAIT: FSM returns to RUN, dmem_req drops on the next edge, and the in-flight request is abandoned.
- Back-to-back memory ops each perform their own handshake. A ready in the same cycle as the request costs no stall.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- When defined: adds output stall_cycles [CNT_W-1:0], which counts cycles with mem_stall=1, resets to 0, and saturates at all-ones.
- When undefined: the port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- ALU op, ex_rd=5, result 0x1234, dmem idle -> next cycle EX_MEM_RegWrite=1, EX_MEM_rd=5, EX_MEM_result=0x1234; following cycle MEM_WB_rd=5, wb_en=1 for exactly 1 cycle.
- Load ex_rd=7 with id_rs2=7 -> load_use_stall=1 that cycle; with id_rs1=id_rs2=0 or ex_rd=0 -> load_use_stall=0.
- Load at addr 0x100, dmem_ready low 3 cycles then rdata 0xDEADBEEF -> dmem_req high 4 cycles with stable addr; mem_stall=1 for 3 cycles; MEM/WB holds prior instruction, wb_en not repeated; then MEM_WB_result=0xDEADBEEF, wb_en=1 once.
- Store rd field 9, ex_RegWrite=0 -> dmem_we=1, wdata=ex_store_data; MEM_WB_RegWrite=0, wb_en=0.
- Assert rst during WAIT -> next cycle dmem_req=0, all RegWrite=0, mem_stall=0, FSM in RUN.
- With PIPE_STALL_CNT_EN: the 3-wait load above -> stall_cycles=3. Counter forced near max -> saturates at all-ones.
